// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } rf_wr_t;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} starve_state_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Small synchronous FIFO of pending multi-cycle register writes.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  rf_wr_t                 din,
    output logic                   full,
    output logic                   empty,
    output rf_wr_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    rf_wr_t      mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= din;
    end

    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered
// multi-cycle results; tracks pending destinations and requests bubbles on starvation.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int MC_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [REG_AW-1:0] mc_rd,
    input  logic [XLEN-1:0]   mc_data,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              hazard,
    output logic              wb_hold,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_ad,
    output logic [XLEN-1:0]   rf_wd
);

    localparam int CW = $clog2(MC_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int NREG = 2 ** REG_AW;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          blocked;
    rf_wr_t        mc_wr;
    rf_wr_t        head;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;

    assign mc_wr    = '{rd: mc_rd, data: mc_data};
    assign mc_ready = !full;
    assign push     = mc_valid && mc_ready;
    assign pop      = !wb_valid && !empty;
    assign blocked  = wb_valid && !empty;
    assign count_n  = count + CW'(push) - CW'(pop);

    rf_arb_fifo #(.DEPTH(MC_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (mc_wr),
        .full  (full),
        .empty (empty),
        .head  (head),
        .count (count)
    );

    // Write port: writeback first, otherwise drain the FIFO head.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_ad <= '0;
            rf_wd <= '0;
        end else if (wb_valid) begin
            rf_we <= (wb_rd != '0);
            rf_ad <= wb_rd;
            rf_wd <= wb_data;
        end else if (!empty) begin
            rf_we <= (head.rd != '0);
            rf_ad <= head.rd;
            rf_wd <= head.data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_n;

    // A fresh issue to the register being drained keeps it pending.
    always_comb begin
        pending_n = pending;
        if (pop)
            pending_n[head.rd] = 1'b0;
        if (issue_valid && issue_rd != '0)
            pending_n[issue_rd] = 1'b1;
        pending_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else
            pending <= pending_n;
    end

    assign hazard = ((chk_rs1 != '0) && pending[chk_rs1]) ||
                    ((chk_rs2 != '0) && pending[chk_rs2]) ||
                    ((chk_rd  != '0) && pending[chk_rd]);

    starve_state_t state;
    starve_state_t state_n;
    logic [SW-1:0] cnt;
    logic [SW-1:0] cnt_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (pop)
            cnt_n = '0;
        else if (blocked && cnt != SW'(STARVE_MAX))
            cnt_n = cnt + 1'b1;

        if (count_n == '0) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE, WAIT: state_n = (cnt_n >= SW'(STARVE_MAX)) ? HOLD : WAIT;
                HOLD:       state_n = pop ? WAIT : HOLD;
                default:    state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    assign wb_hold = (state == HOLD);

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port (WE3/AD3/WD3) between the in-order pipeline writeback and a multi-cycle execution unit (mul/div, slow load). Pipeline writeback always has priority. Multi-cycle results are buffered in a small FIFO and drained in idle writeback slots. A per-register pending scoreboard raises a hazard to the issue stage, and a starvation timer requests a writeback bubble.

## Interface
Parameters:
- MC_DEPTH, 2: FIFO depth for multi-cycle results (power of two, ≥2)
- STARVE_MAX, 4: consecutive blocked cycles before wb_hold asserts (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- wb_valid  in  1  pipeline writeback request; always accepted
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline writeback data
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  FIFO can accept; transfer on mc_valid && mc_ready
- mc_rd  in  5  multi-cycle destination register
- mc_data  in  32  multi-cycle result data
- issue_valid  in  1  multi-cycle op issued this cycle
- issue_rd  in  5  its destination; marked pending
- chk_rs1, chk_rs2, chk_rd  in  5 each  registers of the instruction in issue
- hazard  out  1  any nonzero chk register is pending (combinational)
- wb_hold  out  1  request that the pipeline send no writeback next cycle
- rf_we, rf_ad, rf_wd  out  1/5/32  register-file write port, registered

## Operation
- **Arbitration** each cycle, on registered outputs:
  - wb_valid: rf_we=1 (rd≠0), rf_ad=wb_rd, rf_wd=wb_data. No FIFO pop.
  - Else if FIFO non-empty: pop head and drive it. Clear pending[head.rd] on the pop cycle.
  - Else rf_we=0. rf_ad/rf_wd hold their last value.
- **x0:** requests with rd=0 are accepted and popped normally but produce rf_we=0.
- **FIFO:**
  - mc_ready = count < MC_DEPTH, from the registered count.
  - Push and pop in the same cycle are allowed. Count is unchanged and order is preserved.
  - Strict FIFO order; no bypass to rf on the push cycle.
- **Scoreboard:** pending[31:1] bits; pending[0] is hardwired 0.
  - Set on issue_valid with issue_rd≠0.
  - Same-cycle set and clear of one rd: set wins.
  - hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd], with x0 excluded.
- **Starvation FSM** (states IDLE, WAIT, HOLD; counter width clog2(STARVE_MAX+1)):
  - IDLE: FIFO empty. Counter=0.
  - IDLE→WAIT: FIFO becomes non-empty.
  - WAIT: counter++ each cycle the FIFO is non-empty and wb_valid blocks the pop. Counter resets to 0 on any pop.
  - WAIT→HOLD: counter reaches STARVE_MAX.
  - HOLD: wb_hold=1. Exit to WAIT (counter 0) on a pop, or to IDLE if the FIFO empties.
  - If wb_valid arrives despite wb_hold, writeback still wins. Stay in HOLD.
- **Reset:**
  - rf_we=0, rf_ad=0, rf_wd=0.
  - FIFO emptied, so mc_ready=1 on the cycle after reset.
  - All pending bits 0, hazard=0.
  - FSM=IDLE, counter=0, wb_hold=0.
  - Reset mid-operation discards buffered results and pending bits with no write.

## Timing
- Writeback accepted in cycle N: rf_we/rf_ad/rf_wd valid in cycle N+1.
- mc result accepted in cycle N, FIFO previously empty, wb_valid=0 in N+1: popped in N+1, rf_we in N+2.
  - Minimum mc latency: 2 cycles.
  - pending bit clears at the end of N+1, so hazard drops in N+2.
- mc_ready deasserts the cycle after count reaches MC_DEPTH.
- wb_hold asserts the cycle after the counter reaches STARVE_MAX. It is a registered FSM output.
- hazard is combinational from the registered pending bits and the chk inputs.

## Structure
- Package rf_arb_pkg:
  - XLEN=32, REG_AW=5.
  - typedef struct packed {logic [4:0] rd; logic [31:0] data;} rf_wr_t.
  - typedef enum {IDLE, WAIT, HOLD} starve_state_t.
- Sub-module rf_arb_fifo (parameter DEPTH):
  - Synchronous FIFO of rf_wr_t.
  - Ports: push, pop, full, empty, head, count.
  - Wrap-around pointers with one extra bit.
- Arbiter, scoreboard and FSM live in the top.

## Test plan
1. **Reset:** assert rst 2 cycles.
   - Expect rf_we=0, mc_ready=1, hazard=0, wb_hold=0.
2. **Priority:** drive wb_valid (rd=5, 0x11) and mc_valid (rd=6, 0x22) in the same cycle, then idle.
   - Expect rf writes x5=0x11 at N+1 and x6=0x22 at N+2.
3. **Scoreboard:** issue_valid rd=7, then chk_rs1=7.
   - Expect hazard=1 until the mc result for x7 (0xABCD) is popped.
   - Expect hazard=0 the cycle after rf writes x7.
4. **Full FIFO:** 3 back-to-back mc results with continuous wb_valid.
   - Expect mc_ready=0 after 2 accepts.
   - Third result held until the first pop; rf order is preserved.
5. **Starvation (STARVE_MAX=4):** FIFO holds 1 entry, wb_valid constant.
   - Expect wb_hold=1 on the 5th blocked cycle.
   - Drop wb_valid: pop occurs, wb_hold=0 the next cycle.
6. **x0 and mid-op reset:**
   - mc result with rd=0: accepted, rf_we stays 0.
   - Reset with 2 FIFO entries and pending x9: no rf write afterward, hazard on x9=0.
